// File: rtl/sqlite_txn_scheduler.sv
// Batches records from NUM_REQ requesters into BEGIN / INSERT* / COMMIT transactions for a DPI bridge.
// Optional: define SQLITE_TXN_ROLLBACK_EN to roll back the whole batch on an INSERT error.
module sqlite_txn_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int ROW_W     = 32,
    parameter int BATCH_MAX = 16,
    parameter int FLUSH_TO  = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*ROW_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       cmd_valid,
    input  logic                       cmd_ready,
    output logic [1:0]                 cmd_op,
    output logic [$clog2(NUM_REQ)-1:0] cmd_src,
    output logic [ROW_W-1:0]           cmd_data,
    input  logic                       rsp_valid,
    input  logic                       rsp_err,
    output logic                       txn_open,
    output logic [15:0]                commit_cnt,
    output logic [15:0]                err_cnt
);

    localparam int SRC_W = $clog2(NUM_REQ);

    typedef enum logic [3:0] {
        IDLE, BEGIN, WAIT_B, ARB, INSERT, WAIT_I, COMMIT, WAIT_C, ROLLBACK, WAIT_R
    } state_t;

    typedef enum logic [1:0] {
        OP_BEGIN    = 2'd0,
        OP_INSERT   = 2'd1,
        OP_COMMIT   = 2'd2,
        OP_ROLLBACK = 2'd3
    } op_t;

    state_t           state;
    logic [7:0]       batch_cnt;
    logic [15:0]      idle_cnt;
    logic [SRC_W-1:0] rr_ptr;

    logic             grant_any;
    logic [SRC_W-1:0] grant_idx;
    logic             flush_now;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Round-robin search starting at rr_ptr (one past the last grant).
    always_comb begin
        int unsigned idx;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = SRC_W'(idx);
            end
        end
    end

    // The cycle the idle count would reach FLUSH_TO belongs to the COMMIT, even if a request shows up.
    assign flush_now = (idle_cnt == 16'(FLUSH_TO - 1));

    // req_ready is decoded from current req_valid so it can never point at a requester that dropped valid.
    always_comb begin
        req_ready = '0;
        if (!rst && state == ARB && grant_any && !flush_now)
            req_ready[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cmd_valid  <= 1'b0;
            cmd_op     <= OP_BEGIN;
            cmd_src    <= '0;
            cmd_data   <= '0;
            txn_open   <= 1'b0;
            commit_cnt <= '0;
            err_cnt    <= '0;
            batch_cnt  <= '0;
            idle_cnt   <= '0;
            rr_ptr     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        state     <= BEGIN;
                        cmd_valid <= 1'b1;
                        cmd_op    <= OP_BEGIN;
                    end
                end
                BEGIN: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (rsp_valid) begin
                        if (rsp_err) begin
                            err_cnt <= sat_inc(err_cnt);
                            state   <= IDLE;
                        end else begin
                            txn_open <= 1'b1;
                            state    <= ARB;
                        end
                    end
                end
                ARB: begin
                    if (flush_now) begin
                        idle_cnt  <= '0;
                        cmd_valid <= 1'b1;
                        cmd_op    <= OP_COMMIT;
                        state     <= COMMIT;
                    end else if (grant_any) begin
                        idle_cnt  <= '0;
                        rr_ptr    <= SRC_W'((int'(grant_idx) + 1) % NUM_REQ);
                        cmd_valid <= 1'b1;
                        cmd_op    <= OP_INSERT;
                        cmd_src   <= grant_idx;
                        cmd_data  <= req_data[int'(grant_idx)*ROW_W +: ROW_W];
                        state     <= INSERT;
                    end else begin
                        idle_cnt <= idle_cnt + 16'd1;
                    end
                end
                INSERT: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        cmd_src   <= '0;
                        cmd_data  <= '0;
                        state     <= WAIT_I;
                    end
                end
                WAIT_I: begin
                    if (rsp_valid) begin
                        if (!rsp_err) begin
                            batch_cnt <= batch_cnt + 8'd1;
                            if (batch_cnt == 8'(BATCH_MAX - 1)) begin
                                cmd_valid <= 1'b1;
                                cmd_op    <= OP_COMMIT;
                                state     <= COMMIT;
                            end else begin
                                state <= ARB;
                            end
                        end else begin
                            err_cnt <= sat_inc(err_cnt);
`ifdef SQLITE_TXN_ROLLBACK_EN
                            batch_cnt <= '0;
                            cmd_valid <= 1'b1;
                            cmd_op    <= OP_ROLLBACK;
                            state     <= ROLLBACK;
`else
                            state <= ARB;
`endif
                        end
                    end
                end
                COMMIT: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= WAIT_C;
                    end
                end
                WAIT_C: begin
                    if (rsp_valid) begin
                        if (rsp_err) begin
                            err_cnt   <= sat_inc(err_cnt);
                            cmd_valid <= 1'b1;
                            cmd_op    <= OP_ROLLBACK;
                            state     <= ROLLBACK;
                        end else begin
                            commit_cnt <= commit_cnt + 16'd1;
                            batch_cnt  <= '0;
                            txn_open   <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                end
                ROLLBACK: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= WAIT_R;
                    end
                end
                WAIT_R: begin
                    if (rsp_valid) begin
                        if (rsp_err)
                            err_cnt <= sat_inc(err_cnt);
                        batch_cnt <= '0;
                        txn_open  <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
